// File: rtl/dequantizer.sv
// dequantizer: rebuilds 5-bit magnitudes from quantized samples into a valid/ready FIFO; DEQUANT_DITHER_EN enables lsb dither
module dequantizer #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_q,
    input  logic       in_scale,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [4:0] out_data,
    output logic [7:0] sample_cnt,
    output logic [7:0] scaled_cnt
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    logic [4:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    smp_q, smp_d, scl_q, scl_d;
    logic          push, pop, lsb;
    logic [4:0]    wdata;
    assign in_ready   = cnt_q != CW'(DEPTH);
    assign out_valid  = cnt_q != '0;
    assign push       = in_valid && in_ready;
    assign pop        = out_valid && out_ready;
    assign out_data   = mem_q[rd_q];
    assign sample_cnt = smp_q;
    assign scaled_cnt = scl_q;
    assign wdata      = in_scale ? {in_q, lsb} : {1'b0, in_q};
`ifdef DEQUANT_DITHER_EN
    logic tog_q;
    assign lsb = tog_q;
    // alternate the lsb across successive scaled samples
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tog_q <= 1'b0;
        else if (push && in_scale) tog_q <= ~tog_q;
    end
`else
    assign lsb = 1'b0;
`endif
    // pointer, occupancy and debug counter next state
    always_comb begin
        wr_d  = push ? ((wr_q == AW'(DEPTH - 1)) ? '0 : wr_q + 1'b1) : wr_q;
        rd_d  = pop ? ((rd_q == AW'(DEPTH - 1)) ? '0 : rd_q + 1'b1) : rd_q;
        cnt_d = cnt_q + CW'(push) - CW'(pop);
        smp_d = push ? smp_q + 8'd1 : smp_q;
        scl_d = (push && in_scale && scl_q != 8'hFF) ? scl_q + 8'd1 : scl_q;
    end
    // control state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            smp_q <= '0;
            scl_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
            smp_q <= smp_d;
            scl_q <= scl_d;
        end
    end
    // sample storage, cleared on reset so the idle head reads as zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (push) begin
            mem_q[wr_q] <= wdata;
        end
    end
endmodule
